// File: rtl/seg_disp_arbiter_if.sv
// seg_disp_arbiter_if: requester, half-select and display/scan signals of seg_disp_arbiter
interface seg_disp_arbiter_if;
  logic        req0, req1, half_req, gnt0, gnt1, half_sel, frame_tick;
  logic [31:0] data0, data1, disp_num;
  logic [1:0]  scanning;
  modport master (
    output req0, data0, req1, data1, half_req,
    input  gnt0, gnt1, disp_num, scanning, half_sel, frame_tick
  );
  modport slave (
    input  req0, data0, req1, data1, half_req,
    output gnt0, gnt1, disp_num, scanning, half_sel, frame_tick
  );
endinterface

// File: rtl/seg_disp_arbiter.sv
// seg_disp_arbiter: scan sequencer and frame-aligned two-requester display arbiter
// AUTO_HALF_EN: half_sel toggles every HALF_FRAMES frames instead of following half_req
module seg_disp_arbiter #(
  parameter int SCAN_DIV    = 17,
  parameter int HOLD_FRAMES = 4,
  parameter int HALF_FRAMES = 64
) (
  input logic              clk,
  input logic              rst,
  seg_disp_arbiter_if.slave bus
);
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t              r_state, w_next, w_dec;
  logic [SCAN_DIV-1:0] r_cnt;
  logic [HW-1:0]       r_hold;
  logic [31:0]         r_disp;
  logic                r_last, r_half, w_tick, w_hold_up;
  assign w_tick    = &r_cnt;
  assign w_hold_up = int'(r_hold) + 1 >= HOLD_FRAMES;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_dec = r_state;
    case (r_state)
      OWN0:    w_dec = !bus.req0 ? (bus.req1 ? OWN1 : IDLE) : (bus.req1 && w_hold_up) ? OWN1 : OWN0;
      OWN1:    w_dec = !bus.req1 ? (bus.req0 ? OWN0 : IDLE) : (bus.req0 && w_hold_up) ? OWN0 : OWN1;
      default: w_dec = (bus.req0 && bus.req1) ? (r_last ? OWN0 : OWN1) :
                       bus.req0 ? OWN0 : bus.req1 ? OWN1 : IDLE;
    endcase
    w_next   = w_tick ? w_dec : r_state;
    bus.gnt0 = r_state == OWN0;
    bus.gnt1 = r_state == OWN1;
  end
  // the word is latched only at the tick, so a frame never mixes sources
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt  <= '0;
      r_last <= 1'b1;
      r_hold <= '0;
      r_disp <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (w_tick) begin
        if (w_next != IDLE) r_disp <= (w_next == OWN1) ? bus.data1 : bus.data0;
        if (w_next != r_state) begin
          r_hold <= '0;
          if (w_next != IDLE) r_last <= w_next == OWN1;
        end else if (int'(r_hold) < HOLD_FRAMES) r_hold <= r_hold + 1'b1;
      end
    end
`ifdef AUTO_HALF_EN
  localparam int FW = $clog2(HALF_FRAMES + 1);
  logic [FW-1:0] r_frames;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_frames <= '0;
      r_half   <= 1'b0;
    end else if (w_tick) begin
      r_frames <= (int'(r_frames) + 1 == HALF_FRAMES) ? '0 : r_frames + 1'b1;
      r_half   <= r_half ^ (int'(r_frames) + 1 == HALF_FRAMES);
    end
`else
  always_ff @(posedge clk or posedge rst)
    if (rst)         r_half <= 1'b0;
    else if (w_tick) r_half <= bus.half_req;
`endif
  assign bus.disp_num   = r_disp;
  assign bus.scanning   = r_cnt[SCAN_DIV-1 -: 2];
  assign bus.half_sel   = r_half;
  assign bus.frame_tick = w_tick;
endmodule

// File: tb/tb_seg_disp_arbiter.sv
// tb_seg_disp_arbiter: directed plus random stimulus checked against a frame-level reference model
module tb_seg_disp_arbiter;
  localparam int SD = 4, HOLD = 2, HALF = 3, FRAME = 1 << SD;
  logic clk = 1'b0, rst = 1'b0;
  int n_chk = 0, n_fail = 0;
  int m_cnt, m_own, m_last, m_hold, m_frames;
  logic [31:0] m_disp;
  logic m_half;
  seg_disp_arbiter_if bus();
  seg_disp_arbiter #(.SCAN_DIV(SD), .HOLD_FRAMES(HOLD), .HALF_FRAMES(HALF)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_cnt = 0; m_own = -1; m_last = 1; m_hold = 0; m_disp = 0; m_half = 0; m_frames = 0;
  endtask
  task automatic check_all();
    chk("gnt0", bus.gnt0, m_own == 0);
    chk("gnt1", bus.gnt1, m_own == 1);
    chk("disp_num", bus.disp_num, m_disp);
    chk("scanning", bus.scanning, m_cnt / (FRAME / 4));
    chk("frame_tick", bus.frame_tick, m_cnt == FRAME - 1);
    chk("half_sel", bus.half_sel, m_half);
  endtask
  // advance n clocks; the model reasons per frame: owner, who went last, frames held
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      logic [1:0] r;
      int nxt;
      @(posedge clk);
      r = {bus.req1, bus.req0};
      if (m_cnt == FRAME - 1) begin
        nxt = m_own;
        if (m_own < 0) nxt = (r == 2'b11) ? 1 - m_last : r[0] ? 0 : r[1] ? 1 : -1;
        else if (!r[m_own]) nxt = r[1 - m_own] ? 1 - m_own : -1;
        else if (r[1 - m_own] && m_hold + 1 >= HOLD) nxt = 1 - m_own;
        if (nxt >= 0) m_disp = nxt == 1 ? bus.data1 : bus.data0;
        if (nxt != m_own) begin
          m_hold = 0;
          if (nxt >= 0) m_last = nxt;
        end else m_hold = (m_hold + 1 > HOLD) ? HOLD : m_hold + 1;
        m_own = nxt;
`ifdef AUTO_HALF_EN
        m_frames++;
        if (m_frames == HALF) begin m_frames = 0; m_half = ~m_half; end
`else
        m_half = bus.half_req;
`endif
      end
      m_cnt = (m_cnt + 1) % FRAME;
      #1;
      check_all();
    end
  endtask
  initial begin
    bus.req0 = 0; bus.req1 = 0; bus.data0 = 0; bus.data1 = 0; bus.half_req = 0;
    #2 rst = 1;
    #1 model_reset();
    check_all();
    #1 rst = 0;
    bus.req0 = 1; bus.data0 = 32'h12345678;
    cyc(FRAME - 1);
    chk("t2_before_tick", bus.gnt0, 1'b0);
    cyc(1);
    chk("t2_gnt0", bus.gnt0, 1'b1);
    chk("t2_disp", bus.disp_num, 32'h12345678);
    bus.data0 = 32'hAAAA0000;
    cyc(FRAME);
    chk("t5_first", bus.disp_num, 32'hAAAA0000);
    cyc(4);
    bus.data0 = 32'h0000BBBB;
    cyc(8);
    chk("t5_midframe", bus.disp_num, 32'hAAAA0000);
    cyc(4);
    chk("t5_after_tick", bus.disp_num, 32'h0000BBBB);
    bus.req1 = 1; bus.data1 = 32'hCAFE0001;
    cyc(FRAME + 5);
    chk("t1_gnt1_before_rst", bus.gnt1, 1'b1);
    #1 rst = 1;
    #1 model_reset();
    check_all();
    #2 rst = 0;
    cyc(FRAME);
    chk("t3_first_owner", bus.gnt0, 1'b1);
    cyc(2 * FRAME);
    chk("t3_switch_gnt1", bus.gnt1, 1'b1);
    chk("t3_switch_disp", bus.disp_num, 32'hCAFE0001);
    cyc(2 * FRAME);
    chk("t3_back_gnt0", bus.gnt0, 1'b1);
    chk("t3_back_disp", bus.disp_num, 32'h0000BBBB);
    bus.req0 = 0; bus.req1 = 0;
    cyc(FRAME);
    chk("t4_idle", {bus.gnt1, bus.gnt0}, 2'b00);
    chk("t4_disp_hold", bus.disp_num, 32'h0000BBBB);
    bus.half_req = 1;
    cyc(FRAME);
`ifndef AUTO_HALF_EN
    chk("t6_half_req", bus.half_sel, 1'b1);
`endif
    bus.half_req = 0;
    cyc(3 * FRAME);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) bus.req0 = ~bus.req0;
      if ($urandom_range(0, 19) == 0) bus.req1 = ~bus.req1;
      bus.data0 = $urandom;
      bus.data1 = $urandom;
      if ($urandom_range(0, 7) == 0) bus.half_req = ~bus.half_req;
      cyc(1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
